// File: rtl/gpr_pkg.sv
// Shared types for the GPR access sequencer: op codes, register selectors, FSM states,
// and the strobe bundle that the decoder drives.
package gpr_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_ALU_WB = 2'd2,
    OP_MOVE   = 2'd3
  } op_e;

  localparam logic [1:0] SEL_X   = 2'd0;
  localparam logic [1:0] SEL_Y   = 2'd1;
  localparam logic [1:0] SEL_ACC = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2,
    StMvWr = 2'd3
  } state_e;

  typedef struct packed {
    logic write_x;
    logic write_y;
    logic write_acc;
    logic save_alu;
    logic read_x;
    logic read_y;
  } strobe_t;

endpackage

// File: rtl/gpr_strobe_decode.sv
// Combinational decode of (phase, op, register) into the one-hot register file strobes.
module gpr_strobe_decode
  import gpr_pkg::*;
#(
  parameter int unsigned SEL_W = 2
) (
  input  state_e           phase_i,
  input  op_e              op_i,
  input  logic [SEL_W-1:0] reg_i,
  input  logic [SEL_W-1:0] src_i,
  input  logic             illegal_i,
  output strobe_t          strb_o
);

  always_comb begin
    strb_o = '0;
    if (!illegal_i) begin
      unique case (phase_i)
        StExec: begin
          case (op_i)
            OP_WRITE: begin
              strb_o.write_x   = (reg_i == SEL_W'(SEL_X));
              strb_o.write_y   = (reg_i == SEL_W'(SEL_Y));
              strb_o.write_acc = (reg_i == SEL_W'(SEL_ACC));
            end
            OP_ALU_WB: strb_o.save_alu = 1'b1;
            OP_READ: begin
              strb_o.read_x = (reg_i == SEL_W'(SEL_X));
              strb_o.read_y = (reg_i == SEL_W'(SEL_Y));
            end
            OP_MOVE: begin
              strb_o.read_x = (src_i == SEL_W'(SEL_X));
              strb_o.read_y = (src_i == SEL_W'(SEL_Y));
            end
            default: ;
          endcase
        end
        StMvWr: begin
          strb_o.write_x   = (reg_i == SEL_W'(SEL_X));
          strb_o.write_y   = (reg_i == SEL_W'(SEL_Y));
          strb_o.write_acc = (reg_i == SEL_W'(SEL_ACC));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gpr_access_sequencer.sv
// Initiator for the GPR file: one request at a time -> timed single-cycle strobes + read response.
// Define GPR_SEQ_MOVE_EN to build the register-to-register MOVE path (otherwise MOVE is illegal).
module gpr_access_sequencer
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [SEL_W-1:0]  req_reg_i,
  input  logic [SEL_W-1:0]  req_src_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rf_data_in_o,
  output logic [DATA_W-1:0] rf_data_in_acc_mem_o,
  output logic [DATA_W-1:0] rf_data_in_acc_alu_o,
  output logic              rf_write_x_o,
  output logic              rf_write_y_o,
  output logic              rf_write_acc_o,
  output logic              rf_save_after_alu_o,
  output logic              rf_read_x_o,
  output logic              rf_read_y_o,
  input  logic [DATA_W-1:0] rf_data_out_i,
  input  logic [DATA_W-1:0] rf_data_out_acc_i
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [SEL_W-1:0]  reg_q, src_q;
  logic [DATA_W-1:0] data_q, rsp_q;
  logic              illegal_q;
  logic              accept, req_legal, reg_ok;
  logic [SEL_W-1:0]  rd_sel;
  logic [DATA_W-1:0] rd_val, wr_data;
  strobe_t           strb;

`ifdef GPR_SEQ_MOVE_EN
  logic [DATA_W-1:0] mv_q;
  logic              src_ok;
`endif

  assign req_ready_o = (state_q == StIdle);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    req_legal = 1'b0;
    reg_ok    = (req_reg_i <= SEL_W'(SEL_ACC));
`ifdef GPR_SEQ_MOVE_EN
    src_ok    = (req_src_i <= SEL_W'(SEL_ACC));
`endif
    case (op_e'(req_op_i))
      OP_READ, OP_WRITE: req_legal = reg_ok;
      OP_ALU_WB:         req_legal = (req_reg_i == SEL_W'(SEL_ACC));
`ifdef GPR_SEQ_MOVE_EN
      OP_MOVE:           req_legal = reg_ok && src_ok && (req_src_i != req_reg_i);
`else
      OP_MOVE:           req_legal = 1'b0;
`endif
      default:           req_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: begin
        if (illegal_q)              state_d = StIdle;
        else if (op_q == OP_READ)   state_d = StResp;
`ifdef GPR_SEQ_MOVE_EN
        else if (op_q == OP_MOVE)   state_d = StMvWr;
`endif
        else                        state_d = StIdle;
      end
      StResp: if (rsp_ready_i) state_d = StIdle;
      StMvWr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ACC has its own read port and needs no select; X/Y share rf_data_out.
  assign rd_sel = (op_q == OP_MOVE) ? src_q : reg_q;
  assign rd_val = (rd_sel == SEL_W'(SEL_ACC)) ? rf_data_out_acc_i : rf_data_out_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_q      <= OP_READ;
      reg_q     <= '0;
      src_q     <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
      rsp_q     <= '0;
`ifdef GPR_SEQ_MOVE_EN
      mv_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op_e'(req_op_i);
        reg_q     <= req_reg_i;
        src_q     <= req_src_i;
        data_q    <= req_data_i;
        illegal_q <= !req_legal;
      end
      if (state_q == StExec && !illegal_q && op_q == OP_READ) rsp_q <= rd_val;
`ifdef GPR_SEQ_MOVE_EN
      if (state_q == StExec && !illegal_q && op_q == OP_MOVE) mv_q <= rd_val;
`endif
    end
  end

  gpr_strobe_decode #(
    .SEL_W (SEL_W)
  ) u_decode (
    .phase_i   (state_q),
    .op_i      (op_q),
    .reg_i     (reg_q),
    .src_i     (src_q),
    .illegal_i (illegal_q),
    .strb_o    (strb)
  );

`ifdef GPR_SEQ_MOVE_EN
  assign wr_data = (state_q == StMvWr) ? mv_q : data_q;
`else
  assign wr_data = data_q;
`endif

  assign rf_write_x_o         = strb.write_x;
  assign rf_write_y_o         = strb.write_y;
  assign rf_write_acc_o       = strb.write_acc;
  assign rf_save_after_alu_o  = strb.save_alu;
  assign rf_read_x_o          = strb.read_x;
  assign rf_read_y_o          = strb.read_y;
  assign rf_data_in_o         = (strb.write_x || strb.write_y) ? wr_data : '0;
  assign rf_data_in_acc_mem_o = strb.write_acc ? wr_data : '0;
  assign rf_data_in_acc_alu_o = strb.save_alu ? data_q : '0;

  assign rsp_valid_o = (state_q == StResp);
  assign rsp_data_o  = rsp_valid_o ? rsp_q : '0;
  assign err_o       = (state_q == StExec) && illegal_q;

endmodule

// File: tb/tb_gpr_access_sequencer.sv
// Self-checking bench: a behavioural register file closes the loop around the sequencer,
// and a transaction-level model predicts errors, timing, responses and register contents.
module tb_gpr_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op, req_reg, req_src;
  logic [15:0] req_data;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        err;
  logic [15:0] rf_data_in, rf_acc_mem, rf_acc_alu;
  logic        wr_x, wr_y, wr_acc, save_alu, rd_x, rd_y;
  logic [15:0] rf_data_out, rf_data_out_acc;

  always #5 clk = ~clk;

  gpr_access_sequencer #(
    .DATA_W (16),
    .SEL_W  (2)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .req_valid_i          (req_valid),
    .req_ready_o          (req_ready),
    .req_op_i             (req_op),
    .req_reg_i            (req_reg),
    .req_src_i            (req_src),
    .req_data_i           (req_data),
    .rsp_valid_o          (rsp_valid),
    .rsp_ready_i          (rsp_ready),
    .rsp_data_o           (rsp_data),
    .err_o                (err),
    .rf_data_in_o         (rf_data_in),
    .rf_data_in_acc_mem_o (rf_acc_mem),
    .rf_data_in_acc_alu_o (rf_acc_alu),
    .rf_write_x_o         (wr_x),
    .rf_write_y_o         (wr_y),
    .rf_write_acc_o       (wr_acc),
    .rf_save_after_alu_o  (save_alu),
    .rf_read_x_o          (rd_x),
    .rf_read_y_o          (rd_y),
    .rf_data_out_i        (rf_data_out),
    .rf_data_out_acc_i    (rf_data_out_acc)
  );

  // Behavioural register file driven by the DUT strobes.
  logic [15:0] rf [3];
  initial for (int i = 0; i < 3; i++) rf[i] = 16'h0;
  always @(posedge clk) begin
    if (wr_x)     rf[0] <= rf_data_in;
    if (wr_y)     rf[1] <= rf_data_in;
    if (wr_acc)   rf[2] <= rf_acc_mem;
    if (save_alu) rf[2] <= rf_acc_alu;
  end
  assign rf_data_out     = rd_x ? rf[0] : (rd_y ? rf[1] : 16'h0);
  assign rf_data_out_acc = rf[2];

  typedef struct {
    int err_cnt, wr_cnt, wr_cyc, rd_cnt, rd_cyc, cycles;
    bit got_rsp, inv_bad, timeout;
    logic [15:0] rsp;
  } obs_t;

  typedef struct {
    int err_cnt, wr_cnt, wr_cyc, rd_cnt, rd_cyc, cycles;
    bit has_rsp;
    logic [15:0] rsp;
  } exp_t;

  typedef struct {
    logic [1:0]  op, rg, src;
    logic [15:0] data;
    int          delay, exp_err, exp_cycles;
    bit          has_rsp;
    logic [15:0] exp_rsp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] mregs [4];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: architectural effect of one request, straight from the op rules.
  task automatic model(input logic [1:0] op, input logic [1:0] rg, input logic [1:0] src,
                       input logic [15:0] data, input int delay, output exp_t e);
    bit legal;
    e = '{default: 0};
    case (op)
      2'd0, 2'd1: legal = (rg != 2'd3);
      2'd2:       legal = (rg == 2'd2);
`ifdef GPR_SEQ_MOVE_EN
      default:    legal = (rg != 2'd3) && (src != 2'd3) && (rg != src);
`else
      default:    legal = 1'b0;
`endif
    endcase
    if (!legal) begin
      e.err_cnt = 1;
      e.cycles  = 2;
      return;
    end
    case (op)
      2'd0: begin
        e.rd_cnt  = (rg != 2'd2) ? 1 : 0;
        e.rd_cyc  = e.rd_cnt;
        e.has_rsp = 1'b1;
        e.rsp     = mregs[rg];
        e.cycles  = 3 + delay;
      end
      2'd1, 2'd2: begin
        e.wr_cnt  = 1;
        e.wr_cyc  = 1;
        mregs[rg] = data;
        e.cycles  = 2;
      end
      default: begin
        e.rd_cnt  = (src != 2'd2) ? 1 : 0;
        e.rd_cyc  = e.rd_cnt;
        e.wr_cnt  = 1;
        e.wr_cyc  = 2;
        mregs[rg] = mregs[src];
        e.cycles  = 3;
      end
    endcase
  endtask

  // Issue one request (called at a negedge) and observe until the sequencer is idle again.
  task automatic run_txn(input logic [1:0] op, input logic [1:0] rg, input logic [1:0] src,
                         input logic [15:0] data, input int delay, output obs_t o);
    int cyc, vcnt, n;
    o = '{default: 0};
    cyc = 0;
    while (!req_ready && cyc < 40) begin @(negedge clk); cyc++; end
    if (!req_ready) begin o.timeout = 1'b1; return; end
    req_valid = 1'b1; req_op = op; req_reg = rg; req_src = src; req_data = data;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Scramble request fields: the DUT must use its registered copy.
    req_valid = 1'b0;
    req_op = 2'($urandom); req_reg = 2'($urandom); req_src = 2'($urandom);
    req_data = 16'($urandom);
    cyc = 1; vcnt = 0;
    while (cyc < 40) begin
      if (req_ready) break;
      if (err) o.err_cnt++;
      n = int'(wr_x) + int'(wr_y) + int'(wr_acc) + int'(save_alu);
      if (n > 0) begin o.wr_cnt += n; o.wr_cyc = cyc; end
      if (rd_x || rd_y) begin o.rd_cnt++; o.rd_cyc = cyc; end
      if (n > 1 || (rd_x && rd_y) || (!(wr_x || wr_y) && rf_data_in != 0) ||
          (!wr_acc && rf_acc_mem != 0) || (!save_alu && rf_acc_alu != 0) ||
          (!rsp_valid && rsp_data != 0))
        o.inv_bad = 1'b1;
      if (rsp_valid) begin
        if (!o.got_rsp) begin o.got_rsp = 1'b1; o.rsp = rsp_data; end
        else if (rsp_data != o.rsp) o.inv_bad = 1'b1;
        vcnt++;
        rsp_ready = (vcnt > delay);
      end else begin
        rsp_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    o.cycles = cyc;
    if (!req_ready) o.timeout = 1'b1;
    else if (err || rsp_valid || wr_x || wr_y || wr_acc || save_alu || rd_x || rd_y)
      o.inv_bad = 1'b1;
    rsp_ready = 1'b0;
  endtask

  task automatic check_txn(input string tag, input obs_t o, input exp_t e);
    cmp({tag, ".timeout"}, 64'(o.timeout), 64'(0));
    cmp({tag, ".err"},     64'(o.err_cnt), 64'(e.err_cnt));
    cmp({tag, ".cycles"},  64'(o.cycles),  64'(e.cycles));
    cmp({tag, ".wr_cnt"},  64'(o.wr_cnt),  64'(e.wr_cnt));
    cmp({tag, ".wr_cyc"},  64'(o.wr_cyc),  64'(e.wr_cyc));
    cmp({tag, ".rd_cnt"},  64'(o.rd_cnt),  64'(e.rd_cnt));
    cmp({tag, ".rd_cyc"},  64'(o.rd_cyc),  64'(e.rd_cyc));
    cmp({tag, ".rsp_seen"}, 64'(o.got_rsp), 64'(e.has_rsp));
    if (e.has_rsp) cmp({tag, ".rsp_data"}, 64'(o.rsp), 64'(e.rsp));
    cmp({tag, ".invariants"}, 64'(o.inv_bad), 64'(0));
    cmp({tag, ".regfile"}, {16'h0, rf[0], rf[1], rf[2]}, {16'h0, mregs[0], mregs[1], mregs[2]});
  endtask

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t o;
    exp_t e;
    int   seen;
    for (int i = 0; i < 4; i++) mregs[i] = 16'h0;

    // op, reg, src, data, rsp delay, err, cycles, has_rsp, rsp
    tbl[0]  = '{2'd1, 2'd0, 2'd0, 16'hA5A5, 0, 0, 2, 1'b0, 16'h0};
    tbl[1]  = '{2'd1, 2'd2, 2'd0, 16'h1234, 0, 0, 2, 1'b0, 16'h0};
    tbl[2]  = '{2'd0, 2'd2, 2'd0, 16'h0000, 3, 0, 6, 1'b1, 16'h1234};
    tbl[3]  = '{2'd2, 2'd2, 2'd0, 16'hBEEF, 0, 0, 2, 1'b0, 16'h0};
    tbl[4]  = '{2'd2, 2'd1, 2'd0, 16'h1111, 0, 1, 2, 1'b0, 16'h0};
    tbl[5]  = '{2'd1, 2'd0, 2'd0, 16'hFACE, 0, 0, 2, 1'b0, 16'h0};
`ifdef GPR_SEQ_MOVE_EN
    tbl[6]  = '{2'd3, 2'd1, 2'd0, 16'h0000, 0, 0, 3, 1'b0, 16'h0};
    tbl[7]  = '{2'd0, 2'd1, 2'd0, 16'h0000, 0, 0, 3, 1'b1, 16'hFACE};
`else
    tbl[6]  = '{2'd3, 2'd1, 2'd0, 16'h0000, 0, 1, 2, 1'b0, 16'h0};
    tbl[7]  = '{2'd0, 2'd1, 2'd0, 16'h0000, 0, 0, 3, 1'b1, 16'h0000};
`endif
    tbl[8]  = '{2'd0, 2'd3, 2'd0, 16'h0000, 0, 1, 2, 1'b0, 16'h0};
    tbl[9]  = '{2'd3, 2'd0, 2'd0, 16'h0000, 0, 1, 2, 1'b0, 16'h0};
    tbl[10] = '{2'd0, 2'd0, 2'd0, 16'h0000, 1, 0, 4, 1'b1, 16'hFACE};
    tbl[11] = '{2'd0, 2'd2, 2'd0, 16'h0000, 0, 0, 3, 1'b1, 16'hBEEF};

    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_reg = 2'd0; req_src = 2'd0;
    req_data = 16'h0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset.ctrl", 64'({req_ready, rsp_valid, err, wr_x, wr_y, wr_acc, save_alu, rd_x, rd_y}),
        64'(9'b1_0000_0000));
    cmp("reset.data", 64'(rf_data_in | rf_acc_mem | rf_acc_alu | rsp_data), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      model(tbl[i].op, tbl[i].rg, tbl[i].src, tbl[i].data, tbl[i].delay, e);
      run_txn(tbl[i].op, tbl[i].rg, tbl[i].src, tbl[i].data, tbl[i].delay, o);
      check_txn($sformatf("vec%0d", i), o, e);
      cmp($sformatf("vec%0d.tbl_err", i), 64'(o.err_cnt), 64'(tbl[i].exp_err));
      cmp($sformatf("vec%0d.tbl_cycles", i), 64'(o.cycles), 64'(tbl[i].exp_cycles));
      if (tbl[i].has_rsp) cmp($sformatf("vec%0d.tbl_rsp", i), 64'(o.rsp), 64'(tbl[i].exp_rsp));
    end

    // Reset while a READ Y response is pending: response is dropped and never reappears.
    req_valid = 1'b1; req_op = 2'd0; req_reg = 2'd1; req_src = 2'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    cmp("rst_resp.pre_valid", 64'(rsp_valid), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmp("rst_resp.dropped", 64'({rsp_valid, rsp_data}), 64'(0));
    cmp("rst_resp.ready", 64'(req_ready), 64'(1));
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen++; end
    cmp("rst_resp.no_late_rsp", 64'(seen), 64'(0));
    rsp_ready = 1'b0;

    // Randomized transactions against the model.
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  op, rg, src;
      logic [15:0] data;
      int          dly;
      op   = 2'($urandom_range(0, 3));
      rg   = 2'($urandom_range(0, 3));
      src  = 2'($urandom_range(0, 3));
      data = 16'($urandom);
      dly  = $urandom_range(0, 3);
      model(op, rg, src, data, dly, e);
      run_txn(op, rg, src, data, dly, o);
      check_txn($sformatf("rnd%0d", i), o, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
